shim_trigger_seq_ctrl: RTL and testbench

SHIM_TRIGGER_SEQ_CTRL -- requirements
Module: shim_trigger_seq_ctrl

---
 rtl/shim_trigger_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_shim_trigger_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shim_trigger_seq_ctrl.sv
// Trigger sequencer: replays a small program of trigger-core command words into
// the command FIFO for a set number of passes, with abort via a single CANCEL word.
module shim_trigger_seq_ctrl #(
  parameter int          PROG_DEPTH_LOG2 = 4,
  parameter logic [31:0] CANCEL_WORD     = 32'hE000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_wr_en,
  input  logic [PROG_DEPTH_LOG2-1:0] prog_addr,
  input  logic [31:0]                prog_data,
  input  logic [PROG_DEPTH_LOG2:0]   seq_len,
  input  logic [15:0]                repeat_count,
  input  logic                       start,
  input  logic                       abort,
  output logic                       cmd_word_wr_en,
  output logic [31:0]                cmd_word,
  input  logic                       cmd_buf_full,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                pass_index,
  output logic                       bad_start,
  output logic                       prog_while_busy
);

  localparam int                       DEPTH   = 1 << PROG_DEPTH_LOG2;
  localparam logic [PROG_DEPTH_LOG2:0] MAX_LEN = (PROG_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} state_t;

  state_t                     state_q, state_d;
  logic [PROG_DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [PROG_DEPTH_LOG2:0]   len_q, len_d;
  logic [15:0]                rep_q, rep_d;
  logic [15:0]                pass_q, pass_d;
  logic                       done_q, done_d;
  logic                       bad_q, bad_d;
  logic                       pwb_q, pwb_d;

  logic [31:0] mem [DEPTH];
  logic        last_word;
  logic [16:0] pass_inc;

  // Program memory is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (prog_wr_en && state_q == S_IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign cmd_word_wr_en  = busy && !cmd_buf_full;
  assign cmd_word        = (state_q == S_ABORT) ? CANCEL_WORD : mem[ptr_q];
  assign done            = done_q;
  assign pass_index      = pass_q;
  assign bad_start       = bad_q;
  assign prog_while_busy = pwb_q;

  assign last_word = ({1'b0, ptr_q} == (len_q - 1'b1));
  assign pass_inc  = {1'b0, pass_q} + 17'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    bad_d   = bad_q;
    pwb_d   = pwb_q;

    if (prog_wr_en && busy) begin
      pwb_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (seq_len != '0 && seq_len <= MAX_LEN) begin
            state_d = S_RUN;
            len_d   = seq_len;
            rep_d   = repeat_count;
            ptr_d   = '0;
            pass_d  = '0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cmd_word_wr_en && last_word) begin
          ptr_d  = '0;
          pass_d = pass_inc[16] ? 16'hFFFF : pass_inc[15:0];
        end else if (cmd_word_wr_en) begin
          ptr_d = ptr_q + 1'b1;
        end
        // A completing write outranks a same-cycle abort.
        if (cmd_word_wr_en && last_word && rep_q != 16'd0 && pass_inc == {1'b0, rep_q}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (!cmd_buf_full) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      pwb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
      pwb_q   <= pwb_d;
    end
  end

endmodule

// File: tb/tb_shim_trigger_seq_ctrl.sv
// Bench for shim_trigger_seq_ctrl: table-driven runs, directed corner sequences and
// randomized runs, all checked cycle by cycle against a transaction-level model.
module tb_shim_trigger_seq_ctrl;

  localparam logic [31:0] CANCEL = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_wr_en = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [4:0]  seq_len = '0;
  logic [15:0] repeat_count = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_buf_full = 1'b0;
  logic        cmd_word_wr_en;
  logic [31:0] cmd_word;
  logic        busy;
  logic        done;
  logic [15:0] pass_index;
  logic        bad_start;
  logic        prog_while_busy;

  shim_trigger_seq_ctrl dut (
    .clk(clk), .rst(rst), .prog_wr_en(prog_wr_en), .prog_addr(prog_addr),
    .prog_data(prog_data), .seq_len(seq_len), .repeat_count(repeat_count),
    .start(start), .abort(abort), .cmd_word_wr_en(cmd_word_wr_en),
    .cmd_word(cmd_word), .cmd_buf_full(cmd_buf_full), .busy(busy), .done(done),
    .pass_index(pass_index), .bad_start(bad_start), .prog_while_busy(prog_while_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; int rep; int flo; int fhi; int abw; int abc; int pcyc;
    int e_wr; int e_can; int e_done; int e_pass;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] prog [16];
  int errors = 0;
  int checks = 0;
  int m_writes, m_cancels, m_dones;
  int obs_wr, obs_cancel, obs_done;
  bit pwb_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    prog_wr_en = 1'b1;
    prog_addr  = 4'(a);
    prog_data  = d;
    prog[a]    = d;
    @(negedge clk);
    prog_wr_en = 1'b0;
  endtask

  // Model: the k-th word of a run is prog[k mod len]; a run ends after len*rep words
  // (rep != 0) with a done pulse, or after an abort with exactly one CANCEL word.
  task automatic run_seq(input int len, input int rep, input int flo, input int fhi,
                         input int full_pct, input int abw, input int abc, input int pcyc);
    bit act, abt, dpend, ewr;
    int c, p;
    m_writes = 0; m_cancels = 0; m_dones = 0;
    obs_wr = 0; obs_cancel = 0; obs_done = 0;
    @(negedge clk);
    seq_len = 5'(len); repeat_count = 16'(rep);
    start = 1'b1; abort = 1'b0; cmd_buf_full = 1'b0;
    #1 chk("idle_before_start", 32'(busy), 32'd0);
    act = 1'b1; abt = 1'b0; dpend = 1'b0; c = 0;
    while ((act || dpend) && c < 3000) begin
      c++;
      @(negedge clk);
      start = 1'b0;
      cmd_buf_full = (c >= flo && c <= fhi) || ($urandom_range(99) < full_pct);
      abort = (c == abc);
      prog_wr_en = (c == pcyc);
      prog_addr = '0;
      prog_data = 32'h5555_AAAA;
      if (c == pcyc) pwb_exp = 1'b1;
      #1;
      ewr = act && !cmd_buf_full;
      p = m_writes / len;
      if (p > 65535) p = 65535;
      chk("wr_en", 32'(cmd_word_wr_en), 32'(ewr));
      chk("busy", 32'(busy), 32'(act));
      chk("done", 32'(done), 32'(dpend));
      chk("pass_index", 32'(pass_index), 32'(p));
      if (act) chk("cmd_word", cmd_word, abt ? CANCEL : prog[m_writes % len]);
      if (cmd_word_wr_en) begin
        if (cmd_word == CANCEL) obs_cancel++; else obs_wr++;
      end
      if (done) obs_done++;
      if (ewr && !abt && abw == m_writes + 1) abort = 1'b1;
      dpend = 1'b0;
      if (ewr && abt) begin
        act = 1'b0; abt = 1'b0; m_cancels++;
      end else if (ewr) begin
        m_writes++;
        if (rep != 0 && m_writes == len * rep) begin
          act = 1'b0; dpend = 1'b1; m_dones++;
        end else if (abort) begin
          abt = 1'b1;
        end
      end else if (act && !abt && abort) begin
        abt = 1'b1;
      end
    end
    if (c >= 3000) chk("run_timeout", 32'(c), 32'd0);
    @(negedge clk);
    abort = 1'b0; cmd_buf_full = 1'b0; prog_wr_en = 1'b0;
    #1;
    chk("idle_after_run", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("wr_en_idle", 32'(cmd_word_wr_en), 32'd0);
    chk("prog_while_busy", 32'(prog_while_busy), 32'(pwb_exp));
  endtask

  initial begin
    tbl[0] = '{len:3, rep:2, flo:0, fhi:-1, abw:0,  abc:-1, pcyc:-1, e_wr:6,  e_can:0, e_done:1, e_pass:2};
    tbl[1] = '{len:3, rep:2, flo:2, fhi:4,  abw:0,  abc:-1, pcyc:6,  e_wr:6,  e_can:0, e_done:1, e_pass:2};
    tbl[2] = '{len:1, rep:0, flo:0, fhi:-1, abw:10, abc:-1, pcyc:-1, e_wr:10, e_can:1, e_done:0, e_pass:10};
    tbl[3] = '{len:3, rep:0, flo:4, fhi:8,  abw:0,  abc:5,  pcyc:-1, e_wr:3,  e_can:1, e_done:0, e_pass:1};
    tbl[4] = '{len:2, rep:2, flo:0, fhi:-1, abw:4,  abc:-1, pcyc:-1, e_wr:4,  e_can:0, e_done:1, e_pass:2};
    tbl[5] = '{len:16, rep:1, flo:0, fhi:-1, abw:0, abc:-1, pcyc:-1, e_wr:16, e_can:0, e_done:1, e_pass:1};
    tbl[6] = '{len:4, rep:3, flo:0, fhi:-1, abw:1,  abc:-1, pcyc:-1, e_wr:1,  e_can:1, e_done:0, e_pass:0};

    // Reset values while rst is held
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(cmd_word_wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_index), 32'd0);
    chk("rst_bad_start", 32'(bad_start), 32'd0);
    chk("rst_pwb", 32'(prog_while_busy), 32'd0);
    do_reset();

    // Start qualified by abort in IDLE: ignored entirely
    @(negedge clk); start = 1'b1; abort = 1'b1; seq_len = 5'd0;
    @(negedge clk); seq_len = 5'd3;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_bad", 32'(bad_start), 32'd0);
    // Out-of-range lengths
    @(negedge clk); start = 1'b1; seq_len = 5'd0;
    @(negedge clk); start = 1'b0;
    #1;
    chk("len0_bad", 32'(bad_start), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_wr", 32'(cmd_word_wr_en), 32'd0);
    do_reset();
    #1 chk("bad_cleared", 32'(bad_start), 32'd0);
    @(negedge clk); start = 1'b1; seq_len = 5'd17;
    @(negedge clk); start = 1'b0;
    #1;
    chk("len17_bad", 32'(bad_start), 32'd1);
    chk("len17_busy", 32'(busy), 32'd0);
    do_reset();

    load(0, 32'h2000_0010);
    load(1, 32'h8000_0005);
    load(2, 32'hA000_0000);
    for (int i = 3; i < 16; i++) load(i, 32'h0100_0000 + 32'(i));

    for (int v = 0; v < 7; v++) begin
      run_seq(tbl[v].len, tbl[v].rep, tbl[v].flo, tbl[v].fhi, 0,
              tbl[v].abw, tbl[v].abc, tbl[v].pcyc);
      chk($sformatf("v%0d_writes", v), 32'(obs_wr), 32'(tbl[v].e_wr));
      chk($sformatf("v%0d_cancels", v), 32'(obs_cancel), 32'(tbl[v].e_can));
      chk($sformatf("v%0d_dones", v), 32'(obs_done), 32'(tbl[v].e_done));
      chk($sformatf("v%0d_pass", v), 32'(pass_index), 32'(tbl[v].e_pass));
    end

    // Reset in the middle of a run: writes stop at once and nothing is cancelled
    do_reset();
    pwb_exp = 1'b0;
    @(negedge clk); start = 1'b1; seq_len = 5'd3; repeat_count = 16'd2;
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("midrun_pass", 32'(pass_index), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_wr", 32'(cmd_word_wr_en), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_pass", 32'(pass_index), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1 chk("midrun_rst_hold_wr", 32'(cmd_word_wr_en), 32'd0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 chk("after_rst_idle_wr", 32'(cmd_word_wr_en), 32'd0);
    end
    run_seq(3, 2, 0, -1, 0, 0, -1, -1);
    chk("rerun_writes", 32'(obs_wr), 32'd6);
    chk("rerun_dones", 32'(obs_done), 32'd1);

    // Randomized runs against the model
    for (int i = 0; i < 16; i++) load(i, $urandom & 32'h7FFF_FFFF);
    for (int r = 0; r < 16; r++) begin
      int len, rep, abw;
      len = $urandom_range(16, 1);
      rep = $urandom_range(3, 0);
      if (rep == 0) abw = $urandom_range(3 * len, 1);
      else abw = ($urandom_range(1, 0) == 1) ? $urandom_range(len * rep, 1) : 0;
      run_seq(len, rep, 0, -1, 40, abw, -1, (r == 5) ? 3 : -1);
      $display("rand run %0d: len=%0d rep=%0d abort_at=%0d writes=%0d cancels=%0d dones=%0d",
               r, len, rep, abw, obs_wr, obs_cancel, obs_done);
      chk("rand_writes", 32'(obs_wr), 32'(m_writes));
      chk("rand_cancels", 32'(obs_cancel), 32'(m_cancels));
      chk("rand_dones", 32'(obs_done), 32'(m_dones));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
